rr_mux_sel_arbiter: RTL and testbench
=====================================

// Module: rr_mux_sel_arbiter
// PURPOSE
//  Round-robin arbiter sitting directly upstream of the W-bit N:1 mux
//  (w_bit_N_MUX, inputs a(N-1)..a0). It arbitrates N request lines and
//  drives the mux select. It holds the select stable for one valid/ready
//  beat to the downstream consumer, then rotates priority.
// PARAMETERS
//  N        4    number of requesters / mux inputs (2..16)
//  M        2    select width, must equal clog2(N); matches mux parameter m
//  TIMEOUT  15   stall cycles before forced release (ARB_TIMEOUT_EN only)
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   synchronous, active-high reset
//  req        in   N   request per input; req[i] selects mux input a_i
//  grant      out  N   one-hot grant, registered; all-zero when idle
//  sel        out  M   mux select = index of granted requester, registered
//  out_valid  out  1   selected mux output is valid this cycle
//  out_ready  in   1   downstream accepts the current beat
//  timeout    out  1   1-cycle pulse on forced release (ARB_TIMEOUT_EN only)
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): state=IDLE, ptr=0, grant=0, sel=0,
//    out_valid=0, timeout=0, stall counter=0. Reset overrides all events,
//    including a handshake in the same cycle; no pointer advance occurs.
//  - Winner: lowest i in the rotated order ptr, ptr+1, ..., N-1, 0, ..., ptr-1
//    with req[i]=1. Wrap mod N; sel never takes a value >= N.
//  - States: IDLE, GRANT.
//  - IDLE: if |req -> register winner into sel/grant, out_valid<=1, go GRANT.
//    Latency from req rising to out_valid = 1 cycle. If req=0, stay IDLE.
//  - GRANT: sel/grant held stable; out_valid=1.
//    * out_valid & out_ready: beat done; ptr <= (sel+1) mod N. The next
//      winner is computed from the updated ptr in the same cycle. If there
//      is a winner, stay in GRANT back-to-back with no bubble. Otherwise go
//      IDLE, grant=0 and out_valid=0 next cycle.
//    * req[sel] drops before accept (withdrawal): go IDLE; grant=0,
//      out_valid=0 next cycle; ptr unchanged.
//    * Handshake and withdrawal in the same cycle: handshake wins (beat
//      counted, ptr advances).
//  - sel holds its last value in IDLE; grant=0 is the idle indicator.
//  - grant is always one-hot or zero. grant[sel]=1 whenever out_valid=1.
//  - Changes on req[j], j!=sel, during GRANT never alter sel/grant.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//  - A stall counter increments each GRANT cycle with out_valid=1 and
//    out_ready=0. It clears on handshake or state change.
//  - When the counter reaches TIMEOUT: forced release to IDLE,
//    ptr <= (sel+1) mod N, and timeout pulses high for 1 cycle.
//  ARB_TIMEOUT_EN undefined:
//  - No counter; timeout tied 0.
//  - The grant is held indefinitely until handshake or withdrawal.
// TESTING
//  1. rst=1 two cycles, req=4'b1111 -> grant=0, sel=0, out_valid=0
//     throughout; rst=0 -> 1 cycle later sel=0, grant=4'b0001, out_valid=1.
//  2. req=4'b1111, out_ready=1 constant -> sel sequence 0,1,2,3,0
//     on consecutive cycles, out_valid stays 1 (no bubble).
//  3. ptr=3, req=4'b0101 -> sel=0 (wrap). Accept -> sel=2.
//     Accept with req=0 -> IDLE, grant=0.
//  4. GRANT sel=2, out_ready=0, drop req[2] -> next cycle grant=0,
//     out_valid=0; re-raise req=4'b0100 -> sel=2 again (ptr unchanged).
//  5. GRANT sel=1, assert rst with out_ready=1 -> grant=0, out_valid=0,
//     ptr=0; first grant after reset with req=4'b1110 is sel=1.
//  6. ARB_TIMEOUT_EN, TIMEOUT=15, req=4'b0011, out_ready=0 -> after 15
//     stall cycles timeout pulses; next grant is sel=1. Without the macro,
//     sel=0 is held for 100 cycles.

Source files
------------

// File: rtl/rr_mux_sel_arbiter.sv
// Round-robin arbiter driving the select of a W-bit N:1 mux; one beat per grant.
// Optional stall timeout with forced release is enabled by defining ARB_TIMEOUT_EN.
module rr_mux_sel_arbiter #(
   parameter int unsigned N       = 4,
   parameter int unsigned M       = 2,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [N-1:0] i_req,
   output logic [N-1:0] o_grant,
   output logic [M-1:0] o_sel,
   output logic         o_out_valid,
   input  logic         i_out_ready,
   output logic         o_timeout
);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e       r_state;
   logic [M-1:0] r_ptr;
   logic [M-1:0] r_sel;
   logic [N-1:0] r_grant;
   logic         r_out_valid;
   logic         r_timeout;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT + 1);
   logic [CntW-1:0] r_stall_cnt;
`else
   // Stall limit only matters with the timeout feature; keep the parameter referenced.
   logic w_unused_timeout;
   assign w_unused_timeout = ^32'(TIMEOUT);
`endif

   // Returns {found, index} of the first requester at or after start, wrapping mod N.
   function automatic logic [M:0] pick(input logic [N-1:0] req, input logic [M-1:0] start);
      logic [M:0]   res;
      logic [M-1:0] idx_m;
      int unsigned  idx;
      res = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx   = (32'(start) + k) % N;
         idx_m = M'(idx);
         if (!res[M] && req[idx_m]) res = {1'b1, idx_m};
      end
      return res;
   endfunction

   logic [M:0]   w_idle_pick;
   logic [M:0]   w_next_pick;
   logic [M-1:0] w_sel_inc;
   logic [N-1:0] w_idle_onehot;
   logic [N-1:0] w_next_onehot;

   always_comb begin
      w_sel_inc     = (r_sel == M'(N - 1)) ? '0 : r_sel + M'(1);
      w_idle_pick   = pick(i_req, r_ptr);
      w_next_pick   = pick(i_req, w_sel_inc);
      w_idle_onehot = N'(1) << w_idle_pick[M-1:0];
      w_next_onehot = N'(1) << w_next_pick[M-1:0];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_ptr       <= '0;
         r_sel       <= '0;
         r_grant     <= '0;
         r_out_valid <= 1'b0;
         r_timeout   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         r_stall_cnt <= '0;
`endif
      end else begin
         r_timeout <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         r_stall_cnt <= '0;
`endif
         unique case (r_state)
            StIdle: begin
               if (w_idle_pick[M]) begin
                  r_sel       <= w_idle_pick[M-1:0];
                  r_grant     <= w_idle_onehot;
                  r_out_valid <= 1'b1;
                  r_state     <= StGrant;
               end
            end
            StGrant: begin
               // out_valid is always set in this state, so ready alone completes the beat.
               if (i_out_ready) begin
                  r_ptr <= w_sel_inc;
                  if (w_next_pick[M]) begin
                     r_sel   <= w_next_pick[M-1:0];
                     r_grant <= w_next_onehot;
                  end else begin
                     r_grant     <= '0;
                     r_out_valid <= 1'b0;
                     r_state     <= StIdle;
                  end
               end else if (!i_req[r_sel]) begin
                  r_grant     <= '0;
                  r_out_valid <= 1'b0;
                  r_state     <= StIdle;
`ifdef ARB_TIMEOUT_EN
               end else if (r_stall_cnt == CntW'(TIMEOUT - 1)) begin
                  r_ptr       <= w_sel_inc;
                  r_grant     <= '0;
                  r_out_valid <= 1'b0;
                  r_timeout   <= 1'b1;
                  r_state     <= StIdle;
               end else begin
                  r_stall_cnt <= r_stall_cnt + CntW'(1);
`endif
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_grant     = r_grant;
   assign o_sel       = r_sel;
   assign o_out_valid = r_out_valid;
   assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_rr_mux_sel_arbiter.sv
// Directed self-checking bench for rr_mux_sel_arbiter (N=4); honours ARB_TIMEOUT_EN.
module tb_rr_mux_sel_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] grant;
   logic [1:0] sel;
   logic       out_valid;
   logic       out_ready;
   logic       timeout_o;

   int errors;
   int checks;

   rr_mux_sel_arbiter #(
      .N       (4),
      .M       (2),
      .TIMEOUT (15)
   ) u_dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req       (req),
      .o_grant     (grant),
      .o_sel       (sel),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_timeout   (timeout_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 4'b1111; out_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         step();
         checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
         checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", sel); end
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      end
      rst = 1'b0;
      step();
      checks++; if (sel !== 2'd0) begin errors++; $display("FAIL first_sel: got %0d want 0", sel); end
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL first_grant: got %b want 0001", grant); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b want 1", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_sel [4];
      exp_sel = '{2'd1, 2'd2, 2'd3, 2'd0};
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         checks++; if (sel !== exp_sel[c]) begin errors++; $display("FAIL b2b_sel[%0d]: got %0d want %0d", c, sel, exp_sel[c]); end
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", c, out_valid); end
         checks++; if (grant !== (4'b0001 << exp_sel[c])) begin errors++; $display("FAIL b2b_grant[%0d]: got %b want %b", c, grant, 4'b0001 << exp_sel[c]); end
      end
      out_ready = 1'b0;
   endtask

   task automatic test_wrap();
      req = 4'b0100; out_ready = 1'b1;
      step();
      checks++; if (sel !== 2'd2) begin errors++; $display("FAIL wrap_setup_sel: got %0d want 2", sel); end
      req = 4'b0101;
      step();
      checks++; if (sel !== 2'd0) begin errors++; $display("FAIL wrap_sel: got %0d want 0", sel); end
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL wrap_grant: got %b want 0001", grant); end
      step();
      checks++; if (sel !== 2'd2) begin errors++; $display("FAIL wrap_next_sel: got %0d want 2", sel); end
      req = 4'b0000;
      step();
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL drain_grant: got %b want 0000", grant); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", out_valid); end
      checks++; if (sel !== 2'd2) begin errors++; $display("FAIL idle_sel_hold: got %0d want 2", sel); end
      out_ready = 1'b0;
   endtask

   task automatic test_withdraw();
      req = 4'b0100;
      step();
      checks++; if (sel !== 2'd2) begin errors++; $display("FAIL wd_sel: got %0d want 2", sel); end
      checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL wd_grant: got %b want 0100", grant); end
      req = 4'b0111;
      step();
      checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL other_req_grant: got %b want 0100", grant); end
      req = 4'b0011;
      step();
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL wd_idle_grant: got %b want 0000", grant); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wd_idle_valid: got %b want 0", out_valid); end
      req = 4'b0100;
      step();
      checks++; if (sel !== 2'd2) begin errors++; $display("FAIL wd_regrant_sel: got %0d want 2", sel); end
      // ptr is 3 here; a withdrawal must leave it there.
      req = 4'b0000;
      step();
      req = 4'b1001;
      step();
      checks++; if (sel !== 2'd3) begin errors++; $display("FAIL wd_ptr_kept_sel: got %0d want 3", sel); end
   endtask

   task automatic test_accept_beats_withdraw();
      req = 4'b0001; out_ready = 1'b1;
      step();
      checks++; if (sel !== 2'd0) begin errors++; $display("FAIL hs_wins_sel: got %0d want 0", sel); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hs_wins_valid: got %b want 1", out_valid); end
   endtask

   task automatic test_reset_mid_grant();
      req = 4'b0010; out_ready = 1'b1;
      step();
      checks++; if (sel !== 2'd1) begin errors++; $display("FAIL pre_rst_sel: got %0d want 1", sel); end
      rst = 1'b1; req = 4'b1110;
      step();
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL mid_rst_grant: got %b want 0000", grant); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
      rst = 1'b0;
      step();
      out_ready = 1'b0;
      checks++; if (sel !== 2'd1) begin errors++; $display("FAIL post_rst_sel: got %0d want 1", sel); end
      checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL post_rst_grant: got %b want 0010", grant); end
   endtask

   task automatic test_stall();
      rst = 1'b1;
      step();
      rst = 1'b0; req = 4'b0011; out_ready = 1'b0;
      step();
      checks++; if (sel !== 2'd0) begin errors++; $display("FAIL stall_start_sel: got %0d want 0", sel); end
`ifdef ARB_TIMEOUT_EN
      for (int c = 1; c < 15; c++) begin
         step();
         checks++; if (out_valid !== 1'b1 || timeout_o !== 1'b0) begin errors++; $display("FAIL stall_hold[%0d]: got valid=%b timeout=%b want 1/0", c, out_valid, timeout_o); end
      end
      step();
      checks++; if (timeout_o !== 1'b1) begin errors++; $display("FAIL timeout_pulse: got %b want 1", timeout_o); end
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL timeout_grant: got %b want 0000", grant); end
      step();
      checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b want 0", timeout_o); end
      checks++; if (sel !== 2'd1) begin errors++; $display("FAIL timeout_next_sel: got %0d want 1", sel); end
`else
      for (int c = 0; c < 100; c++) begin
         step();
         checks++; if (sel !== 2'd0 || out_valid !== 1'b1 || timeout_o !== 1'b0) begin errors++; $display("FAIL hold[%0d]: got sel=%0d valid=%b timeout=%b want 0/1/0", c, sel, out_valid, timeout_o); end
      end
`endif
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1; req = 4'b1111; out_ready = 1'b0;
      test_reset();
      test_back_to_back();
      test_wrap();
      test_withdraw();
      test_accept_beats_withdraw();
      test_reset_mid_grant();
      test_stall();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
